// File: rtl/module_bin_bcd.sv
// Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
// One shift per clock; the result is published with a one-cycle listo pulse.
module module_bin_bcd #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      numero_input,
  input  logic                  inicio,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  listo,
  output logic                  ocupado
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [WIDTH-1:0] r_bin;
  logic [BW-1:0]   r_scratch;
  logic [BW-1:0]   w_corr;
  logic [BW-1:0]   r_bcd;
  logic [CW-1:0]   r_cnt;
  logic            r_listo;
  logic            r_ocupado;

  // Add 3 to every BCD digit that is 5 or more, all digits in parallel.
  function automatic logic [BW-1:0] f_add3(input logic [BW-1:0] s);
    logic [3:0] d;
    f_add3 = s;
    for (int i = 0; i < DIGITS; i++) begin
      d = s[4*i +: 4];
      if (d >= 4'd5) begin
        f_add3[4*i +: 4] = d + 4'd3;
      end else begin
        f_add3[4*i +: 4] = d;
      end
    end
  endfunction

  assign w_corr = f_add3(r_scratch);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (inicio) begin
          w_next = S_SHIFT;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_next = S_DONE;
        end else begin
          w_next = S_SHIFT;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: capture, shift with correction, publish; outputs are registered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_bin     <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_bcd     <= '0;
      r_listo   <= 1'b0;
      r_ocupado <= 1'b0;
    end else begin
      r_listo   <= 1'b0;
      r_ocupado <= (w_next != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (inicio) begin
            r_bin     <= numero_input;
            r_scratch <= '0;
            r_cnt     <= '0;
          end else begin
            r_cnt     <= r_cnt;
          end
        end
        S_SHIFT: begin
          {r_scratch, r_bin} <= {w_corr[BW-2:0], r_bin, 1'b0};
          r_cnt              <= r_cnt + CW'(1);
        end
        S_DONE: begin
          // Only a finished conversion ever reaches bcd_out.
          r_bcd   <= r_scratch;
          r_listo <= 1'b1;
        end
        default: begin
          r_cnt <= '0;
        end
      endcase
    end
  end

  assign bcd_out = r_bcd;
  assign listo   = r_listo;
  assign ocupado = r_ocupado;

endmodule
